// File: rtl/ibex_mem_crypt.sv
// Load/store encryption stage between the Ibex LSU and the data bus.
// Lockable key register plus an iterative per-address cipher, one round per cycle.
module ibex_mem_crypt #(
  parameter int unsigned Rounds = 4,
  parameter int unsigned RotAmt = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_we_i,
  input  logic [31:0] key_wdata_i,
  input  logic        key_lock_i,
  output logic        key_locked_o,
  output logic [31:0] key_rdata_o,
  input  logic        lsu_req_i,
  output logic        lsu_gnt_o,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_enc_i,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  localparam logic [2:0] LastRound = 3'(Rounds - 1);
  localparam logic [4:0] Rot       = 5'(RotAmt);

  typedef enum logic [2:0] {IDLE, ENC, REQ, WAIT, DEC, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] key_q;
  logic        key_locked_q;
  logic        we_q, enc_q, err_q;
  logic [31:0] addr_q, d_q, key_snap_q;
  logic [3:0]  be_q;
  logic [2:0]  cnt_q;
  logic [2:0]  round;
  logic [31:0] round_key, enc_d, dec_d;
  logic        bad_store, last_round;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} >> s;
    return t[31:0];
  endfunction

  assign bad_store  = lsu_we_i & lsu_enc_i & (lsu_be_i != 4'hF);
  assign last_round = (cnt_q == LastRound);

  // Decryption walks the round keys in reverse order.
  always_comb begin
    round     = (state_q == DEC) ? (LastRound - cnt_q) : cnt_q;
    round_key = rotl32(key_snap_q, {round[1:0], 3'b000}) ^ addr_q;
    enc_d     = rotl32(d_q ^ round_key, Rot);
    dec_d     = rotr32(d_q, Rot) ^ round_key;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q        <= 32'h0;
      key_locked_q <= 1'b0;
    end else if (key_we_i && !key_locked_q) begin
      key_q        <= key_wdata_i;
      key_locked_q <= key_lock_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // d_q holds store data / ciphertext on the way out and load data on the way back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q       <= 1'b0;
      enc_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      d_q        <= 32'h0;
      key_snap_q <= 32'h0;
      cnt_q      <= 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            we_q       <= lsu_we_i;
            enc_q      <= lsu_enc_i;
            err_q      <= bad_store;
            addr_q     <= lsu_addr_i;
            be_q       <= lsu_be_i;
            d_q        <= lsu_wdata_i;
            key_snap_q <= key_q;
            cnt_q      <= 3'd0;
          end
        end
        ENC: begin
          d_q   <= enc_d;
          cnt_q <= cnt_q + 3'd1;
        end
        WAIT: begin
          if (data_rvalid_i) begin
            d_q   <= data_rdata_i;
            err_q <= data_err_i;
            cnt_q <= 3'd0;
          end
        end
        DEC: begin
          d_q   <= dec_d;
          cnt_q <= cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    lsu_gnt_o    = 1'b0;
    data_req_o   = 1'b0;
    lsu_rvalid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        lsu_gnt_o = lsu_req_i & ~rst_i;
        if (lsu_req_i) begin
          if (bad_store)                state_d = RESP;
          else if (lsu_we_i && lsu_enc_i) state_d = ENC;
          else                          state_d = REQ;
        end
      end
      ENC: begin
        if (last_round) state_d = REQ;
      end
      REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (data_rvalid_i) begin
          if (!we_q && enc_q && !data_err_i) state_d = DEC;
          else                               state_d = RESP;
        end
      end
      DEC: begin
        if (last_round) state_d = RESP;
      end
      RESP: begin
        lsu_rvalid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_we_o    = data_req_o & we_q;
  assign data_addr_o  = data_req_o ? addr_q : 32'h0;
  assign data_be_o    = data_req_o ? be_q : 4'h0;
  assign data_wdata_o = (data_req_o && we_q) ? d_q : 32'h0;

  assign lsu_rdata_o  = (lsu_rvalid_o && !we_q && !err_q) ? d_q : 32'h0;
  assign lsu_err_o    = lsu_rvalid_o & err_q;

  assign key_locked_o = key_locked_q;
  assign key_rdata_o  = key_locked_q ? 32'h0 : key_q;

endmodule

// File: tb/tb_ibex_mem_crypt.sv
// Scoreboard bench for ibex_mem_crypt: stimulus pushes expected LSU responses,
// a negedge monitor pops and compares them whenever lsu_rvalid_o is seen.
module tb_ibex_mem_crypt;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        key_we_i = 1'b0, key_lock_i = 1'b0;
  logic [31:0] key_wdata_i = '0;
  logic        key_locked_o;
  logic [31:0] key_rdata_o;
  logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0, lsu_enc_i = 1'b0;
  logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
  logic [3:0]  lsu_be_i = '0;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
  logic [31:0] data_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sbQ[$];
  resp_t monExp;

  ibex_mem_crypt dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .key_we_i(key_we_i), .key_wdata_i(key_wdata_i), .key_lock_i(key_lock_i),
    .key_locked_o(key_locked_o), .key_rdata_o(key_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_gnt_o(lsu_gnt_o), .lsu_we_i(lsu_we_i),
    .lsu_addr_i(lsu_addr_i), .lsu_be_i(lsu_be_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_enc_i(lsu_enc_i), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_we_o(data_we_o), .data_addr_o(data_addr_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Response monitor, decoupled from stimulus.
  always @(negedge clk_i) begin
    if (lsu_rvalid_o === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rvalid: got rvalid=1 rdata=0x%08h, expected no response", lsu_rdata_o);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("resp_rdata", lsu_rdata_o, monExp.rdata);
        checkOutput("resp_err", 32'(lsu_err_o), 32'(monExp.err));
      end
    end
  end

  // One full LSU transaction with a cooperative bus model. Latencies count cycles
  // after the LSU grant (req) or after the bus rvalid cycle (resp).
  task automatic applyStimulus(
    input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
    input logic enc, input int expReqLat, input logic chkWdata, input logic [31:0] expBusWdata,
    input int gntWait, input int rvGap, input logic [31:0] busRdata, input logic busErr,
    input int expRespLat, input logic [31:0] expRdata, input logic expErr,
    output logic [31:0] seenWdata);
    int n;
    logic sawReq;
    resp_t r;
    seenWdata = '0;
    lsu_we_i = we; lsu_addr_i = addr; lsu_be_i = be; lsu_wdata_i = wdata; lsu_enc_i = enc;
    lsu_req_i = 1'b1;
    #1;
    checkOutput("lsu_gnt", 32'(lsu_gnt_o), 32'd1);
    r.rdata = expRdata;
    r.err   = expErr;
    sbQ.push_back(r);
    stepCycle();
    lsu_req_i = 1'b0;
    key_we_i  = 1'b0;
    n = 1;
    if (expReqLat < 0) begin
      sawReq = 1'b0;
      while (!lsu_rvalid_o && n < 50) begin
        sawReq |= data_req_o;
        stepCycle();
        n++;
      end
      sawReq |= data_req_o;
      checkOutput("no_bus_req", 32'(sawReq), 32'd0);
      checkOutput("resp_latency", 32'(n), 32'(expRespLat));
      stepCycle();
    end else begin
      while (!data_req_o && n < 50) begin
        stepCycle();
        n++;
      end
      checkOutput("req_latency", 32'(n), 32'(expReqLat));
      checkOutput("bus_we", 32'(data_we_o), 32'(we));
      checkOutput("bus_addr", data_addr_o, addr);
      checkOutput("bus_be", 32'(data_be_o), 32'(be));
      if (chkWdata) checkOutput("bus_wdata", data_wdata_o, expBusWdata);
      seenWdata = data_wdata_o;
      for (int i = 0; i < gntWait; i++) begin
        stepCycle();
        checkOutput("bus_hold_req", 32'(data_req_o), 32'd1);
        checkOutput("bus_hold_addr", data_addr_o, addr);
        checkOutput("bus_hold_wdata", data_wdata_o, seenWdata);
      end
      data_gnt_i = 1'b1;
      stepCycle();
      data_gnt_i = 1'b0;
      for (int i = 1; i < rvGap; i++) stepCycle();
      data_rvalid_i = 1'b1; data_rdata_i = busRdata; data_err_i = busErr;
      stepCycle();
      data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
      n = 1;
      while (!lsu_rvalid_o && n < 50) begin
        stepCycle();
        n++;
      end
      checkOutput("resp_latency", 32'(n), 32'(expRespLat));
      stepCycle();
    end
  endtask

  task automatic writeKey(input logic [31:0] val, input logic lock);
    key_we_i = 1'b1; key_wdata_i = val; key_lock_i = lock;
    stepCycle();
    key_we_i = 1'b0; key_lock_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] cw, rk, ra, rd;
    stepCycle();
    stepCycle();
    checkOutput("rst_data_req", 32'(data_req_o), 32'd0);
    checkOutput("rst_lsu_rvalid", 32'(lsu_rvalid_o), 32'd0);
    checkOutput("rst_lsu_gnt", 32'(lsu_gnt_o), 32'd0);
    checkOutput("rst_key_locked", 32'(key_locked_o), 32'd0);
    checkOutput("rst_key_rdata", key_rdata_o, 32'h0);
    checkOutput("rst_data_wdata", data_wdata_o, 32'h0);
    rst_i = 1'b0;
    stepCycle();

    // key 0, addr 0: four rotl-by-7 rounds of 1 give rotl-by-28
    applyStimulus(1, 32'h0, 4'hF, 32'h1, 1, 5, 1, 32'h1000_0000, 0, 1, 32'h0, 0, 1, 32'h0, 0, cw);
    applyStimulus(0, 32'h0, 4'hF, 32'h0, 1, 1, 0, 32'h0, 0, 2, 32'h1000_0000, 0, 5, 32'h1, 0, cw);
    applyStimulus(0, 32'h100, 4'hF, 32'h0, 0, 1, 0, 32'h0, 0, 3, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 0, cw);
    applyStimulus(1, 32'h2000_0040, 4'hC, 32'hCAFE_BABE, 0, 1, 1, 32'hCAFE_BABE, 2, 1, 32'h0, 0, 1, 32'h0, 0, cw);
    applyStimulus(1, 32'h0, 4'b0011, 32'h1, 1, -1, 0, 32'h0, 0, 1, 32'h0, 0, 1, 32'h0, 1, cw);
    applyStimulus(0, 32'h0, 4'hF, 32'h0, 1, 1, 0, 32'h0, 0, 1, 32'h1000_0000, 1, 1, 32'h0, 1, cw);
    applyStimulus(0, 32'h0, 4'b0011, 32'h0, 1, 1, 0, 32'h0, 0, 1, 32'h1000_0000, 0, 5, 32'h1, 0, cw);

    // Key write coincident with the grant: old key (0) protects this store.
    key_we_i = 1'b1; key_wdata_i = 32'hA5A5_A5A5; key_lock_i = 1'b0;
    applyStimulus(1, 32'h0, 4'hF, 32'h1, 1, 5, 1, 32'h1000_0000, 0, 1, 32'h0, 0, 1, 32'h0, 0, cw);
    checkOutput("key_rdata_new", key_rdata_o, 32'hA5A5_A5A5);
    applyStimulus(1, 32'h0, 4'hF, 32'h0, 1, 5, 1, 32'h5555_5555, 0, 1, 32'h0, 0, 1, 32'h0, 0, cw);

    writeKey(32'hA5A5_A5A5, 1'b1);
    checkOutput("key_locked", 32'(key_locked_o), 32'd1);
    checkOutput("key_rdata_locked", key_rdata_o, 32'h0);
    writeKey(32'h1234_5678, 1'b0);
    checkOutput("key_still_locked", 32'(key_locked_o), 32'd1);
    applyStimulus(1, 32'h0, 4'hF, 32'h0, 1, 5, 1, 32'h5555_5555, 0, 1, 32'h0, 0, 1, 32'h0, 0, cw);
    applyStimulus(0, 32'h0, 4'hF, 32'h0, 1, 1, 0, 32'h0, 0, 1, 32'h5555_5555, 0, 5, 32'h0, 0, cw);

    rst_i = 1'b1;
    stepCycle();
    rst_i = 1'b0;
    checkOutput("rst_key_unlocked", 32'(key_locked_o), 32'd0);
    checkOutput("rst_key_zero", key_rdata_o, 32'h0);

    for (int t = 0; t < 3; t++) begin
      rk = $urandom;
      ra = $urandom & 32'hFFFF_FFFC;
      rd = $urandom;
      writeKey(rk, 1'b0);
      applyStimulus(1, ra, 4'hF, rd, 1, 5, 0, 32'h0, 0, 1, 32'h0, 0, 1, 32'h0, 0, cw);
      applyStimulus(0, ra, 4'hF, 32'h0, 1, 1, 0, 32'h0, 0, 1, cw, 0, 5, rd, 0, cw);
    end

    // Reset while ENC is running: no bus request, no response afterwards.
    lsu_we_i = 1'b1; lsu_enc_i = 1'b1; lsu_be_i = 4'hF; lsu_addr_i = 32'h80; lsu_wdata_i = 32'h77;
    lsu_req_i = 1'b1;
    stepCycle();
    lsu_req_i = 1'b0;
    stepCycle();
    rst_i = 1'b1;
    stepCycle();
    rst_i = 1'b0;
    checkOutput("enc_rst_req", 32'(data_req_o), 32'd0);
    checkOutput("enc_rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
    for (int i = 0; i < 6; i++) stepCycle();
    checkOutput("enc_rst_req_later", 32'(data_req_o), 32'd0);

    // Reset in REQ with the bus grant still pending, then a stray rvalid.
    lsu_we_i = 1'b0; lsu_enc_i = 1'b0; lsu_addr_i = 32'h84;
    lsu_req_i = 1'b1;
    stepCycle();
    lsu_req_i = 1'b0;
    checkOutput("req_pending", 32'(data_req_o), 32'd1);
    rst_i = 1'b1;
    stepCycle();
    rst_i = 1'b0;
    checkOutput("req_rst_req", 32'(data_req_o), 32'd0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111;
    stepCycle();
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    stepCycle();

    // Reset in WAIT, then a normal transaction.
    lsu_req_i = 1'b1;
    stepCycle();
    lsu_req_i = 1'b0;
    data_gnt_i = 1'b1;
    stepCycle();
    data_gnt_i = 1'b0;
    rst_i = 1'b1;
    stepCycle();
    rst_i = 1'b0;
    checkOutput("wait_rst_req", 32'(data_req_o), 32'd0);
    applyStimulus(0, 32'h40, 4'hF, 32'h0, 0, 1, 0, 32'h0, 0, 1, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 0, cw);

    for (int i = 0; i < 5; i++) stepCycle();
    checkOutput("scoreboard_drain", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
